// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store sequencer.
//   size_e    : access size encoding as presented on req_size (2'b11 illegal)
//   state_e   : sequencer states
//   misaligned: 1 when size/address combination must be rejected
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RESP
  } state_e;

  localparam int unsigned LANE_W     = 8;
  localparam int unsigned WORD_BYTES = 4;

  // Illegal size (2'b11) is folded in here so acceptance has a single error test.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response handshake bundle between the core memory stage and dmem_ctrl.
//   master : core side (drives requests, accepts responses)
//   slave  : controller side
interface dmem_ctrl_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic shared by the load and read-modify-write paths.
//   word_i     : word read from DataMem
//   new_i      : right-aligned store data
//   lane_i     : byte address bits [1:0]
//   size_i     : access size
//   unsigned_i : zero-extend loads when 1
//   ld_data_o  : extracted and extended load data
//   st_word_o  : word_i with the addressed lane(s) replaced by new_i
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] new_i,
  input  logic [1:0]  lane_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [4:0]  b_shift;
  logic [4:0]  h_shift;
  logic [31:0] b_mask;
  logic [31:0] h_mask;
  logic [7:0]  b_val;
  logic [15:0] h_val;

  always_comb begin
    b_shift   = {lane_i, 3'b000};
    h_shift   = {lane_i[1], 4'b0000};
    b_mask    = 32'h0000_00ff << b_shift;
    h_mask    = 32'h0000_ffff << h_shift;
    b_val     = 8'(word_i >> b_shift);
    h_val     = 16'(word_i >> h_shift);
    ld_data_o = word_i;
    st_word_o = new_i;
    case (size_i)
      SZ_B: begin
        ld_data_o = unsigned_i ? {24'h0, b_val} : {{24{b_val[LANE_W-1]}}, b_val};
        // Replicating the byte across all lanes lets the mask pick the target lane.
        st_word_o = (word_i & ~b_mask) | ({WORD_BYTES{new_i[7:0]}} & b_mask);
      end
      SZ_H: begin
        ld_data_o = unsigned_i ? {16'h0, h_val} : {{16{h_val[15]}}, h_val};
        st_word_o = (word_i & ~h_mask) | ({2{new_i[15:0]}} & h_mask);
      end
      default: begin
        ld_data_o = word_i;
        st_word_o = new_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store sequencer between the core memory stage and a word-wide DataMem.
//   clk, rst   : clock and synchronous active-high reset
//   bus        : request/response handshake (slave side)
//   mem_addr   : word-aligned DataMem address
//   mem_wdata  : DataMem write data
//   mem_rdata  : DataMem read data
//   mem_rw     : DataMem write strobe, high only in WR and never during reset
// Sub-word stores are done as read-modify-write; misaligned or illegal-size
// requests are answered with rsp_err without any memory access.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BIG_RD_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  dmem_ctrl_if.slave        bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              mem_rw
);

  localparam int unsigned CNT_W = (BIG_RD_LAT > 0) ? $clog2(BIG_RD_LAT + 1) : 1;

  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  rd_cnt_q,    rd_cnt_d;
  logic              we_q,        we_d;
  size_e             size_q,      size_d;
  logic              uns_q,       uns_d;
  logic [1:0]        lane_q,      lane_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_rw_q,    mem_rw_d;

  logic [31:0] ld_data;
  logic [31:0] st_word;

  dmem_lane_unit u_lane (
    .word_i     (mem_rdata),
    .new_i      (wdata_q),
    .lane_i     (lane_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .ld_data_o  (ld_data),
    .st_word_o  (st_word)
  );

  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_rw        = mem_rw_q && !rst;

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rw_d    = mem_rw_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          size_d   = size_e'(bus.req_size);
          uns_d    = bus.req_unsigned;
          lane_d   = bus.req_addr[1:0];
          wdata_d  = bus.req_wdata;
          rd_cnt_d = '0;
          if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            state_d     = RESP;
          end else begin
            mem_addr_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
            if (bus.req_we && (bus.req_size == SZ_W)) begin
              mem_wdata_d = bus.req_wdata;
              mem_rw_d    = 1'b1;
              state_d     = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD: begin
        if (rd_cnt_q == CNT_W'(BIG_RD_LAT)) begin
          if (we_q) begin
            mem_wdata_d = st_word;
            mem_rw_d    = 1'b1;
            state_d     = WR;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = ld_data;
            rsp_err_d   = 1'b0;
            state_d     = RESP;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
      end
      WR: begin
        mem_rw_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      we_q        <= 1'b0;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      lane_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rw_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rw_q    <= mem_rw_d;
    end
  end

endmodule
